// File: rtl/spi_controller_if.sv
// Request/status handshake plus the three SPI wires of the register-write controller.
// The master side issues requests and observes the bus; the slave side is the controller.
interface spi_controller_if;
    logic       start;
    logic [3:0] addr;
    logic [7:0] data;
    logic       ready;
    logic       done;
    logic       err;
    logic       SCLK;
    logic       COPI;
    logic       nCS;

    modport master (output start, addr, data, input ready, done, err, SCLK, COPI, nCS);
    modport slave  (input start, addr, data, output ready, done, err, SCLK, COPI, nCS);
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: each accepted request becomes two nCS-framed bytes
// ({1,000,addr} then data), with every bus edge timed off clk for the peripheral's synchronizers.
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FRAME, GAPW} state_t;

    localparam int HW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP);
    localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GMAX = GW'(GAP - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          tail_q, tail_d;
    logic          bsel_q, bsel_d;
    logic [6:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          sclk_q, sclk_d;
    logic          copi_q, copi_d;
    logic          ncs_q, ncs_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            gcnt_q  <= '0;
            bit_q   <= '0;
            tail_q  <= 1'b0;
            bsel_q  <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            gcnt_q  <= gcnt_d;
            bit_q   <= bit_d;
            tail_q  <= tail_d;
            bsel_q  <= bsel_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        bit_d   = bit_q;
        tail_d  = tail_q;
        bsel_d  = bsel_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.addr > 4'd4) begin
                        err_d = 1'b1;
                    end else begin
                        // Byte 1 MSB is the fixed write bit, so COPI starts at 1.
                        state_d = FRAME;
                        ncs_d   = 1'b0;
                        copi_d  = 1'b1;
                        shreg_d = {3'b000, bus.addr};
                        data_d  = bus.data;
                        bsel_d  = 1'b0;
                        hcnt_d  = '0;
                        bit_d   = '0;
                        tail_d  = 1'b0;
                    end
                end
            end
            FRAME: begin
                if (hcnt_q == HMAX) begin
                    hcnt_d = '0;
                    if (tail_q) begin
                        ncs_d   = 1'b1;
                        state_d = GAPW;
                        gcnt_d  = '0;
                    end else if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: present the next bit, or park COPI low after bit 0.
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            tail_d = 1'b1;
                            copi_d = 1'b0;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            copi_d  = shreg_q[6];
                            shreg_d = {shreg_q[5:0], 1'b0};
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            GAPW: begin
                if (gcnt_q == GMAX) begin
                    if (!bsel_q) begin
                        state_d = FRAME;
                        bsel_d  = 1'b1;
                        ncs_d   = 1'b0;
                        copi_d  = data_q[7];
                        shreg_d = data_q[6:0];
                        hcnt_d  = '0;
                        bit_d   = '0;
                        tail_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.SCLK  = sclk_q;
    assign bus.COPI  = copi_q;
    assign bus.nCS   = ncs_q;
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a bus monitor decodes frames into a peripheral register model.
module tb_spi_controller;
    logic clk;
    logic rst;
    spi_controller_if bus();

    spi_controller #(.CLK_DIV(4), .GAP(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // bus monitor state
    int cyc = 0;
    int bitcnt = 0, rises = 0, lowrun = 0, highrun = 0;
    int copi_viol = 0, idle_viol = 0;
    logic p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0;
    logic [7:0] sh = '0, first = '0;
    bit have_first = 0;
    logic [7:0] regs [0:4];
    logic [7:0] frames[$];
    int rise_q[$], low_q[$], hi_q[$], fall_q[$], done_q[$];

    initial begin
        for (int i = 0; i < 5; i++) regs[i] = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.nCS && bus.SCLK) idle_viol++;
            if (bus.done) done_q.push_back(cyc);
            if (!bus.nCS) begin
                if (p_ncs) begin
                    hi_q.push_back(highrun);
                    fall_q.push_back(cyc);
                    highrun = 0; bitcnt = 0; rises = 0; lowrun = 0;
                end
                lowrun++;
                if (bus.SCLK && !p_sclk) begin
                    sh = {sh[6:0], bus.COPI};
                    bitcnt++;
                    rises++;
                end
                if (!p_ncs && bus.COPI !== p_copi && !(p_sclk && !bus.SCLK)) copi_viol++;
            end else begin
                if (!p_ncs) begin
                    low_q.push_back(lowrun);
                    rise_q.push_back(rises);
                    if (bitcnt == 8) begin
                        frames.push_back(sh);
                        if (!have_first) begin
                            first = sh;
                            have_first = 1;
                        end else begin
                            if (first[7] && first[3:0] <= 4'd4) regs[int'(first[3:0])] = sh;
                            have_first = 0;
                        end
                    end else begin
                        have_first = 0;
                    end
                    highrun = 0;
                end
                highrun++;
            end
            p_sclk = bus.SCLK;
            p_ncs  = bus.nCS;
            p_copi = bus.COPI;
        end
    end

    task automatic clear_mon();
        frames.delete(); rise_q.delete(); low_q.delete();
        hi_q.delete(); fall_q.delete(); done_q.delete();
        copi_viol = 0;
        idle_viol = 0;
    endtask

    task automatic issue(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.addr = a; bus.data = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.nCS !== 1'b1) begin n_bad++; $display("FAIL reset_ncs: got %b want 1", bus.nCS); end
        n_cmp++; if (bus.SCLK !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", bus.SCLK); end
        n_cmp++; if (bus.COPI !== 1'b0) begin n_bad++; $display("FAIL reset_copi: got %b want 0", bus.COPI); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.nCS !== 1'b1 || bus.SCLK !== 1'b0 || bus.ready !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL reset_idle_hold: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        issue(4'd0, 8'hA5);
        wait_done(400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_done_timeout: got %b want 1", ok); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_with_done: got %b want 1", bus.ready); end
        repeat (3) @(posedge clk);
        n_cmp++; if (frames.size() !== 2) begin n_bad++; $display("FAIL single_nframes: got %0d want 2", frames.size()); end
        if (frames.size() == 2 && low_q.size() == 2 && hi_q.size() == 2 && done_q.size() == 1) begin
            n_cmp++; if (frames[0] !== 8'h80) begin n_bad++; $display("FAIL single_byte1: got %h want 80", frames[0]); end
            n_cmp++; if (frames[1] !== 8'hA5) begin n_bad++; $display("FAIL single_byte2: got %h want a5", frames[1]); end
            n_cmp++; if (rise_q[0] !== 8 || rise_q[1] !== 8) begin n_bad++; $display("FAIL single_rises: got %0d/%0d want 8/8", rise_q[0], rise_q[1]); end
            n_cmp++; if (low_q[0] !== 68 || low_q[1] !== 68) begin n_bad++; $display("FAIL single_ncs_low: got %0d/%0d want 68/68", low_q[0], low_q[1]); end
            n_cmp++; if (hi_q[1] !== 8) begin n_bad++; $display("FAIL single_gap: got %0d want 8", hi_q[1]); end
            n_cmp++; if (done_q[0] - fall_q[0] !== 152) begin n_bad++; $display("FAIL single_latency: got %0d want 152", done_q[0] - fall_q[0]); end
        end
        n_cmp++; if (regs[0] !== 8'hA5) begin n_bad++; $display("FAIL single_reg0: got %h want a5", regs[0]); end
        n_cmp++; if (copi_viol !== 0) begin n_bad++; $display("FAIL single_copi_stable: got %0d want 0", copi_viol); end
        n_cmp++; if (idle_viol !== 0) begin n_bad++; $display("FAIL single_sclk_idle: got %0d want 0", idle_viol); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        clear_mon();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.addr = 4'd4; bus.data = 8'h80;
        @(posedge clk); #1;
        bus.addr = 4'd2; bus.data = 8'hFF;
        wait_done(400, ok1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(400, ok2);
        repeat (3) @(posedge clk);
        n_cmp++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin n_bad++; $display("FAIL b2b_done_timeout: got %b%b want 11", ok1, ok2); end
        n_cmp++; if (frames.size() !== 4) begin n_bad++; $display("FAIL b2b_nframes: got %0d want 4", frames.size()); end
        if (frames.size() == 4 && fall_q.size() == 4 && done_q.size() >= 1) begin
            n_cmp++; if ({frames[0], frames[1], frames[2], frames[3]} !== 32'h8480_82FF) begin n_bad++; $display("FAIL b2b_bytes: got %h%h%h%h want 848082ff", frames[0], frames[1], frames[2], frames[3]); end
            n_cmp++; if (fall_q[2] !== done_q[0] + 1) begin n_bad++; $display("FAIL b2b_accept_on_done: got %0d want %0d", fall_q[2], done_q[0] + 1); end
            n_cmp++; if (hi_q[2] !== 9) begin n_bad++; $display("FAIL b2b_interframe_high: got %0d want 9", hi_q[2]); end
        end
        n_cmp++; if (done_q.size() !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_q.size()); end
        n_cmp++; if (regs[4] !== 8'h80) begin n_bad++; $display("FAIL b2b_reg4: got %h want 80", regs[4]); end
        n_cmp++; if (regs[2] !== 8'hFF) begin n_bad++; $display("FAIL b2b_reg2: got %h want ff", regs[2]); end
    endtask

    task automatic test_err();
        int bad;
        clear_mon();
        issue(4'd7, 8'h12);
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %b want 1", bus.err); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL err_ready: got %b want 1", bus.ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b want 0", bus.err); end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.nCS !== 1'b1 || bus.SCLK !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL err_no_activity: got %0d bad cycles want 0", bad); end
        n_cmp++; if (fall_q.size() !== 0) begin n_bad++; $display("FAIL err_no_frame: got %0d want 0", fall_q.size()); end
    endtask

    task automatic test_ignore_busy();
        bit ok;
        clear_mon();
        issue(4'd3, 8'h5A);
        repeat (30) @(posedge clk);
        issue(4'd2, 8'h77);
        wait_done(400, ok);
        repeat (200) @(posedge clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ignore_done_timeout: got %b want 1", ok); end
        n_cmp++; if (done_q.size() !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", done_q.size()); end
        n_cmp++; if (frames.size() !== 2) begin n_bad++; $display("FAIL ignore_nframes: got %0d want 2", frames.size()); end
        if (frames.size() == 2) begin
            n_cmp++; if ({frames[0], frames[1]} !== 16'h835A) begin n_bad++; $display("FAIL ignore_bytes: got %h%h want 835a", frames[0], frames[1]); end
        end
        n_cmp++; if (regs[3] !== 8'h5A) begin n_bad++; $display("FAIL ignore_reg3: got %h want 5a", regs[3]); end
        n_cmp++; if (regs[2] !== 8'hFF) begin n_bad++; $display("FAIL ignore_reg2: got %h want ff", regs[2]); end
    endtask

    task automatic test_reset_mid();
        bit found, ok;
        clear_mon();
        issue(4'd3, 8'hEE);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.nCS && bitcnt == 3) begin found = 1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_bit3: got %b want 1", found); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.nCS !== 1'b1 || bus.SCLK !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got ncs=%b sclk=%b want 1/0", bus.nCS, bus.SCLK); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        n_cmp++; if (frames.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_frame: got %0d want 0", frames.size()); end
        n_cmp++; if (regs[3] !== 8'h5A) begin n_bad++; $display("FAIL rstmid_reg3_kept: got %h want 5a", regs[3]); end
        issue(4'd1, 8'h3C);
        wait_done(400, ok);
        repeat (3) @(posedge clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_done_timeout: got %b want 1", ok); end
        n_cmp++; if (regs[1] !== 8'h3C) begin n_bad++; $display("FAIL rstmid_reg1: got %h want 3c", regs[1]); end
        n_cmp++; if (regs[3] !== 8'h5A) begin n_bad++; $display("FAIL rstmid_reg3_after: got %h want 5a", regs[3]); end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.addr = 4'd0;
        bus.data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_err();
        test_ignore_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
